// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - register file write/read port arbiter between core writeback and debug access
// Optional feature macro: RF_ARB_X0_FILTER_EN (suppress register file writes to index 0)
module rf_access_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_we,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wd,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        rf_rs_sel,
  output logic [4:0]  rf_rs_addr,
  input  logic [31:0] rf_rs_data
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  starve_cnt;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        grant;

  // Debug wins immediately when the core is not writing, or once it has waited out the starvation limit
  assign grant = (state == IDLE) && dbg_req && (!core_we || (starve_cnt == LIMIT));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Count core-write cycles a pending debug request has lost, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (state == IDLE) begin
      if (!dbg_req || grant)
        starve_cnt <= 8'd0;
      else if (core_we && (starve_cnt != LIMIT))
        starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Capture the debug request on the grant edge so the requester's inputs may change afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_addr  <= 5'd0;
      req_wdata <= 32'd0;
    end else if (grant) begin
      req_we    <= dbg_we;
      req_addr  <= dbg_addr;
      req_wdata <= dbg_wdata;
    end
  end

  // Read data is registered at the end of the read access cycle and held until the next read
  always_ff @(posedge clk) begin
    if (rst)                                dbg_rdata <= 32'd0;
    else if ((state == ACCESS) && !req_we)  dbg_rdata <= rf_rs_data;
  end

  // Next-state logic: a single access cycle followed by a single acknowledge cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Port steering; reset forces the idle view so nothing of an aborted access leaks out
  always_comb begin
    rf_we      = core_we;
    rf_rd      = core_rd;
    rf_wd      = core_wd;
    core_stall = 1'b0;
    rf_rs_sel  = 1'b0;
    rf_rs_addr = 5'd0;
    dbg_ack    = 1'b0;
    if (!rst) begin
      case (state)
        ACCESS: begin
          core_stall = 1'b1;
          rf_we      = req_we;
          rf_rd      = req_addr;
          rf_wd      = req_wdata;
          if (!req_we) begin
            rf_rs_sel  = 1'b1;
            rf_rs_addr = req_addr;
          end
        end
        ACK:     dbg_ack = 1'b1;
        default: ;
      endcase
    end
`ifdef RF_ARB_X0_FILTER_EN
    if (rf_rd == 5'd0) rf_we = 1'b0;
`else
    // Index-0 writes pass through; the register file itself discards them
`endif
  end

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, max consecutive core-write cycles a pending debug request waits before forced grant (range 1..255).
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 core_we  in  1  core writeback enable.
REQ-005 core_rd  in  5  core writeback register index.
REQ-006 core_wd  in  32  core writeback data.
REQ-007 core_stall  out  1  core must hold pipeline and writeback inputs stable.
REQ-008 dbg_req  in  1  debug access request, held high until dbg_ack.
REQ-009 dbg_we  in  1  debug access type: 1 write, 0 read.
REQ-010 dbg_addr  in  5  debug register index.
REQ-011 dbg_wdata  in  32  debug write data.
REQ-012 dbg_ack  out  1  one-cycle access-complete pulse.
REQ-013 dbg_rdata  out  32  registered read data, valid when dbg_ack=1.
REQ-014 rf_we / rf_rd / rf_wd  out  1/5/32  register file write port.
REQ-015 rf_rs_sel  out  1  steer register file read port 1 to rf_rs_addr.
REQ-016 rf_rs_addr  out  5  debug read index.
REQ-017 rf_rs_data  in  32  register file read port 1 data.

Function
REQ-018 FSM states IDLE, ACCESS, ACK; one debug access in flight max.
REQ-019 IDLE and ACK: rf_we=core_we, rf_rd=core_rd, rf_wd=core_wd; core_stall=0; rf_rs_sel=0.
REQ-020 IDLE->ACCESS when dbg_req=1 and (core_we=0 or starve_cnt=STARVE_LIMIT); dbg_we/addr/wdata latched on that edge.
REQ-021 starve_cnt (8 bit): in IDLE, +1 when dbg_req=1 and core_we=1, saturating at STARVE_LIMIT; cleared when dbg_req=0 or on IDLE->ACCESS.
REQ-022 ACCESS lasts exactly one cycle; core_stall=1; core_we not forwarded.
REQ-023 ACCESS write: rf_we=1, rf_rd=latched addr, rf_wd=latched wdata.
REQ-024 ACCESS read: rf_we=0, rf_rs_sel=1, rf_rs_addr=latched addr; dbg_rdata<=rf_rs_data at end of cycle.
REQ-025 ACCESS->ACK unconditionally; ACK asserts dbg_ack=1 for one cycle, then ACK->IDLE.
REQ-026 dbg_req in ACK ignored; a new request is evaluated in IDLE only (minimum 3 cycles between acks).
REQ-027 dbg_rdata unchanged by debug writes; read of index 0 returns whatever rf_rs_data supplies (0).
REQ-028 Request-to-ack latency: 2 cycles from IDLE->ACCESS edge; unbounded wait limited to STARVE_LIMIT+1 IDLE cycles.
REQ-029 Core writeback during ACCESS is not lost: core holds it under stall and it is forwarded in ACK cycle.

Reset
REQ-030 rst=1 at posedge: state=IDLE, starve_cnt=0, latched request=0, dbg_rdata=0.
REQ-031 During/after reset outputs: dbg_ack=0, core_stall=0, rf_rs_sel=0, rf_rs_addr=0; rf_we follows core_we pass-through.
REQ-032 Reset mid-access (ACCESS or ACK) aborts without ack; requester must re-issue.

Configuration
REQ-033 Macro RF_ARB_X0_FILTER_EN defined: rf_we forced 0 whenever driven index is 0 (core or debug); debug write to x0 still acked.
REQ-034 Macro undefined: writes to index 0 forwarded unfiltered; register file discards them.

Verification
REQ-035 core_we=0, dbg_req write addr=5 data=0xDEADBEEF -> ACCESS next cycle, rf_we=1 rf_rd=5 rf_wd=0xDEADBEEF, core_stall=1 one cycle, dbg_ack two cycles after grant edge.
REQ-036 Debug read addr=5 after REQ-035 -> rf_rs_sel=1 rf_rs_addr=5 in ACCESS, dbg_ack with dbg_rdata=0xDEADBEEF.
REQ-037 core_we=1 continuously, dbg_req held, STARVE_LIMIT=8 -> forced grant after 8 waiting cycles, core_stall exactly one cycle, no core write lost.
REQ-038 rst pulse during ACCESS -> no dbg_ack, dbg_rdata=0, state IDLE, core_stall=0 next cycle.
REQ-039 Debug write addr=0 data=0x1234 -> dbg_ack=1; rf_we=0 with RF_ARB_X0_FILTER_EN, rf_we=1 rf_rd=0 without.
